// File: rtl/mpwm.sv
// mpwm: bus-programmable multi-channel PWM with a shared prescaler.
//
// Ports:
//   clk    - system clock, everything advances on its rising edge
//   rst    - asynchronous active-high reset
//   din    - write data (DW bits)
//   addr   - register address (AW bits)
//   we     - 1 = write this cycle, 0 = read this cycle
//   dout   - registered read data; holds during write cycles
//   pwm_p  - per-channel PWM output (registered)
//   pwm_n  - per-channel complement of pwm_p (registered)
//   irq    - |(IFLG & IEN)
//
// Map: 0x00 TDIV, 0x01 IFLG (W1C), 0x02 IEN,
//      0x10+4c CTR, 0x11+4c ATS, 0x12+4c CMP, 0x13+4c CNT (RO).

// One PWM channel: control/top/compare registers, shadows, counter and output.
module mpwm_ch #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_tick,
    input  logic          i_wr_ctr,
    input  logic          i_wr_ats,
    input  logic          i_wr_cmp,
    input  logic [DW-1:0] i_din,
    output logic [3:0]    o_ctr,
    output logic [DW-1:0] o_ats,
    output logic [DW-1:0] o_cmp,
    output logic [DW-1:0] o_cnt,
    output logic          o_pend,
    output logic          o_pwm_p,
    output logic          o_pwm_n
);
    localparam logic [DW-1:0] ONE = DW'(1);

    logic [3:0]    r_ctr;
    logic [DW-1:0] r_ats, r_cmp, r_ats_s, r_cmp_s, r_cnt;
    logic          r_dir;      // 0 = counting up, 1 = counting down
    logic          r_pwm_p, r_pwm_n;

    logic [DW-1:0] w_cnt_nx;
    logic          w_dir_nx, w_wrap, w_pend, w_pwm;

    // Counter step for one tick; w_wrap flags the period-end step.
    // Comparisons use >= so a counter can never step past the top.
    always_comb begin
        w_cnt_nx = r_cnt;
        w_dir_nx = r_dir;
        w_wrap   = 1'b0;
        if (!r_ctr[2]) begin
            w_dir_nx = 1'b0;
            if (r_cnt >= r_ats_s) begin
                w_cnt_nx = '0;
                w_wrap   = 1'b1;
            end else begin
                w_cnt_nx = r_cnt + ONE;
            end
        end else if (r_ats_s == '0) begin
            w_cnt_nx = '0;
            w_dir_nx = 1'b0;
            w_wrap   = 1'b1;
        end else if (!r_dir) begin
            if (r_cnt >= r_ats_s) begin
                w_cnt_nx = r_cnt - ONE;
                w_dir_nx = 1'b1;
            end else begin
                w_cnt_nx = r_cnt + ONE;
            end
        end else begin
            if (r_cnt == '0) begin
                w_cnt_nx = ONE;
                w_dir_nx = 1'b0;
                w_wrap   = 1'b1;
            end else begin
                w_cnt_nx = r_cnt - ONE;
            end
        end
    end

    assign w_pend = r_ctr[0] & i_tick & w_wrap;
    assign w_pwm  = (r_cnt <= r_cmp_s) ? r_ctr[1] : ~r_ctr[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctr   <= '0;
            r_ats   <= '0;
            r_cmp   <= '0;
            r_ats_s <= '0;
            r_cmp_s <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_pwm_p <= 1'b0;
            r_pwm_n <= 1'b1;
        end else begin
            if (i_wr_ats) r_ats <= i_din;
            if (i_wr_cmp) r_cmp <= i_din;
            // A bus write beats the one-shot auto-clear in the same cycle.
            if (i_wr_ctr)
                r_ctr <= i_din[3:0];
            else if (w_pend && r_ctr[3])
                r_ctr[0] <= 1'b0;

            if (!r_ctr[0]) begin
                r_cnt   <= '0;
                r_dir   <= 1'b0;
                r_ats_s <= r_ats;
                r_cmp_s <= r_cmp;
            end else if (i_tick) begin
                if (w_wrap) begin
                    r_ats_s <= r_ats;
                    r_cmp_s <= r_cmp;
                end
                r_cnt <= (w_wrap && r_ctr[3]) ? '0   : w_cnt_nx;
                r_dir <= (w_wrap && r_ctr[3]) ? 1'b0 : w_dir_nx;
            end

            r_pwm_p <= w_pwm;
            r_pwm_n <= ~w_pwm;
        end
    end

    assign o_ctr   = r_ctr;
    assign o_ats   = r_ats;
    assign o_cmp   = r_cmp;
    assign o_cnt   = r_cnt;
    assign o_pend  = w_pend;
    assign o_pwm_p = r_pwm_p;
    assign o_pwm_n = r_pwm_n;
endmodule

module mpwm #(
    parameter int DW  = 16,
    parameter int AW  = 13,
    parameter int NCH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  din,
    input  logic [AW-1:0]  addr,
    input  logic           we,
    output logic [DW-1:0]  dout,
    output logic [NCH-1:0] pwm_p,
    output logic [NCH-1:0] pwm_n,
    output logic           irq
);
    localparam logic [DW-1:0] ONE = DW'(1);

    logic [DW-1:0]  r_tdiv, r_tdiv_s, r_div, r_dout;
    logic [NCH-1:0] r_iflg, r_ien;

    logic                     w_tick;
    logic [NCH-1:0]           w_pend, w_wr_ctr, w_wr_ats, w_wr_cmp;
    logic [NCH-1:0][3:0]      w_ctr;
    logic [NCH-1:0][DW-1:0]   w_ats, w_cmp, w_cnt;
    logic [DW-1:0]            w_rd;

    // Prescaler: the active divider only reloads at wrap so a rate change
    // never cuts the current prescaler period short.
    assign w_tick = (r_div == r_tdiv_s);

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_ch
            assign w_wr_ctr[c] = we && (addr == AW'(16 + 4*c));
            assign w_wr_ats[c] = we && (addr == AW'(17 + 4*c));
            assign w_wr_cmp[c] = we && (addr == AW'(18 + 4*c));
            mpwm_ch #(.DW(DW)) u_ch (
                .clk      (clk),
                .rst      (rst),
                .i_tick   (w_tick),
                .i_wr_ctr (w_wr_ctr[c]),
                .i_wr_ats (w_wr_ats[c]),
                .i_wr_cmp (w_wr_cmp[c]),
                .i_din    (din),
                .o_ctr    (w_ctr[c]),
                .o_ats    (w_ats[c]),
                .o_cmp    (w_cmp[c]),
                .o_cnt    (w_cnt[c]),
                .o_pend   (w_pend[c]),
                .o_pwm_p  (pwm_p[c]),
                .o_pwm_n  (pwm_n[c])
            );
        end
    endgenerate

    // Read mux; anything not matched reads 0.
    always_comb begin
        w_rd = '0;
        if (addr == AW'(0)) w_rd = r_tdiv;
        if (addr == AW'(1)) w_rd = DW'(r_iflg);
        if (addr == AW'(2)) w_rd = DW'(r_ien);
        for (int i = 0; i < NCH; i++) begin
            if (addr == AW'(16 + 4*i)) w_rd = {{(DW-4){1'b0}}, w_ctr[i]};
            if (addr == AW'(17 + 4*i)) w_rd = w_ats[i];
            if (addr == AW'(18 + 4*i)) w_rd = w_cmp[i];
            if (addr == AW'(19 + 4*i)) w_rd = w_cnt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tdiv   <= '0;
            r_tdiv_s <= '0;
            r_div    <= '0;
            r_iflg   <= '0;
            r_ien    <= '0;
            r_dout   <= '0;
        end else begin
            if (we && addr == AW'(0)) r_tdiv <= din;
            if (we && addr == AW'(2)) r_ien  <= din[NCH-1:0];
            // Write-1-to-clear first, then OR in hardware sets so a set wins.
            r_iflg <= (r_iflg & ~((we && addr == AW'(1)) ? din[NCH-1:0] : '0)) | w_pend;

            if (w_tick) begin
                r_div    <= '0;
                r_tdiv_s <= r_tdiv;
            end else begin
                r_div <= r_div + ONE;
            end

            if (!we) r_dout <= w_rd;
        end
    end

    assign dout = r_dout;
    assign irq  = |(r_iflg & r_ien);
endmodule

// File: doc/mpwm.md
MPWM -- requirements
Module: mpwm

Interface
REQ-001 Parameter DW, default 16, bus data width and width of every register.
REQ-002 Parameter AW, default 13, bus address width.
REQ-003 Parameter NCH, default 4, number of PWM channels; legal range 1..8.
REQ-004 clk  input  1  single system clock; all logic rises on posedge clk.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 din  input  DW  write data.
REQ-007 addr  input  AW  register address.
REQ-008 we  input  1  high = write this cycle; low = read this cycle.
REQ-009 dout  output  DW  registered read data.
REQ-010 pwm_p  output  NCH  per-channel PWM, registered.
REQ-011 pwm_n  output  NCH  per-channel complement of pwm_p, registered.
REQ-012 irq  output  1  interrupt, equal to |(IFLG & IEN).

Function
REQ-013 The register map SHALL be: 0x00 TDIV (prescaler), 0x01 IFLG (period flags, write-1-to-clear), 0x02 IEN (interrupt enable).
REQ-014 Each channel c SHALL have: 0x10+4c CTR, 0x11+4c ATS (top), 0x12+4c CMP (compare), 0x13+4c CNT (read-only).
REQ-015 CTR bits SHALL be: [0] enable, [1] polarity, [2] mode (0 = edge/up, 1 = center/up-down), [3] one-shot; [DW-1:4] SHALL read 0.
REQ-016 The bus SHALL accept a write when we=1; writes to read-only or unmapped addresses SHALL be ignored; dout SHALL hold its value during write cycles.
REQ-017 On a read (we=0), dout SHALL present the addressed register on the next clock edge; unmapped addresses SHALL read 0.
REQ-018 The prescaler SHALL count DIV_CNT 0..TDIV_r and assert a one-clock tick on the cycle DIV_CNT==TDIV_r, then wrap to 0.
REQ-019 TDIV_r SHALL load TDIV only at prescaler wrap.
REQ-020 Each channel SHALL have shadows ATS_r and CMP_r; while disabled they SHALL track ATS and CMP every cycle.
REQ-021 While enabled, shadows SHALL load only at period end.
REQ-022 A disabled channel SHALL hold CNT=0 with direction = up.
REQ-023 Edge mode: on each tick CNT SHALL increment; a tick with CNT==ATS_r SHALL instead set CNT=0 and constitute period end.
REQ-024 Center mode, up direction: on each tick CNT SHALL increment; a tick with CNT==ATS_r SHALL decrement instead and set direction down.
REQ-025 Center mode, down direction: on each tick CNT SHALL decrement; a tick with CNT==0 SHALL increment instead, set direction up, and constitute period end.
REQ-026 Center mode with ATS_r==0 SHALL hold CNT=0, with every tick a period end.
REQ-027 At period end, IFLG[c] SHALL be set.
REQ-028 At period end with CTR[3]=1, CTR[0] SHALL be cleared by hardware and CNT SHALL be 0.
REQ-029 If IFLG[c] is set by hardware and cleared by write in the same cycle, the set SHALL win.
REQ-030 The PWM outputs SHALL register, every clock: pwm_p[c] = CTR[1] if CNT<=CMP_r, else ~CTR[1]; pwm_n[c] = ~pwm_p[c]. Output lags CNT by one clock.
REQ-031 Writing CTR[0]=0 mid-period SHALL take effect next clock: CNT=0, direction up, shadows tracking.
REQ-032 A bus write to CTR in the same cycle as a one-shot auto-clear SHALL take precedence.
REQ-033 Registers at or above bit NCH of IFLG and IEN SHALL read 0.
REQ-034 All counter arithmetic SHALL be DW-bit unsigned and SHALL never wrap past ATS_r or below 0.

Reset
REQ-035 rst=1 SHALL immediately clear every register, shadow, prescaler, counter, direction bit, IFLG and IEN.
REQ-036 During rst=1: dout=0, pwm_p=0, pwm_n=all ones, irq=0.
REQ-037 After rst falls, the first prescaler tick SHALL occur on the first clock, since TDIV_r=0.

Verification
REQ-038 Edge mode: TDIV=0, ATS0=9, CMP0=4, CTR0=0x1 -> pwm_p[0] low 5 clocks, high 5 clocks, period 10; IFLG[0] set every 10 clocks.
REQ-039 Center mode: ATS0=4, CMP0=1, CTR0=0x5 -> CNT 0,1,2,3,4,3,2,1,0,1... (period 8 ticks); pwm_p[0] high while CNT>1; flag set at each return to 0.
REQ-040 Prescaler: TDIV=2 -> CNT advances every 3 clocks; writing TDIV=0 mid-count -> new rate starts only after the current prescaler wrap.
REQ-041 Shadow: during a running period, write CMP0 from 4 to 7 -> duty unchanged until period end, then high time 2 of 10.
REQ-042 One-shot/IRQ: IEN=1, ATS0=3, CTR0=0x9 -> CNT 0..3 then CTR0 reads 0x8, CNT holds 0, irq=1; writing IFLG=1 clears irq; set and clear in the same cycle -> IFLG[0] stays 1.
REQ-043 Async reset: assert rst between clock edges mid-period on two channels -> outputs reach reset values before the next edge; all registers read 0 afterwards.
